regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
Parametrised, command-driven CPU register file and successor of the 8-entry ALU regfile command set.
- Generalised in data width, register count and special-register placement.
- Adds a valid/ready command handshake and a registered, back-pressurable read-result port.
- Adds stack-pointer increment/decrement with sticky wrap flags in F, and a multi-cycle CLEARALL sweep.
- Sits between the decode/sequencer stage and the ALU operand/result buses.

Parameters:
DATA_WIDTH, 16, register width in bits
REGISTERS, 8, number of registers (>=4)
INDEX_WIDTH, $clog2(REGISTERS), register index width
RV_IDX, REGISTERS-3, index of return-value register
SP_IDX, REGISTERS-2, index of stack pointer
F_IDX, REGISTERS-1, index of flags register
SP_STEP, 2, SP increment/decrement amount
SP_RESET, 0, SP value after reset and after CLEARALL

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  4  opcode (see Behaviour)
cmd_sel  in  3*INDEX_WIDTH  {sel_c, sel_b, sel_a} for LATCHSEL
cmd_data  in  DATA_WIDTH  write data for LATCH* ops
rd_valid  out  1  read result valid
rd_ready  in  1  consumer accepts result
rd_data  out  DATA_WIDTH  read result
busy  out  1  high during CLEARALL sweep

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All registers 0, except reg[SP_IDX]=SP_RESET.
  - sel_a/b/c=0, rd_valid=0, rd_data=0, busy=0, state=IDLE.
  - cmd_ready=1 once reset deasserts.
- Opcodes:
  - 0 NOP.
  - 1 READA: reg[sel_a]. 2 READB: reg[sel_b].
  - 3 LATCHC: reg[sel_c]<=cmd_data.
  - 4 LATCHSEL: latch the three cmd_sel fields.
  - 5 READSP, 6 READF, 7 READRV.
  - 8 LATCHSP, 9 LATCHF, A LATCHRV.
  - B INCSP, C DECSP.
  - D reserved (NOP).
  - E CLEARALL.
  - F reserved (NOP).
- Read latency: a read accepted at edge N gives rd_valid=1 with data after edge N. The data reflects every write accepted before edge N.
- rd_valid/rd_data hold stable until rd_valid&&rd_ready.
- cmd_ready = (state==IDLE) && !(rd_valid && !rd_ready). A stalled output blocks every command type, writes included, to preserve ordering.
- Read completing while a new read is accepted in the same cycle: rd_data is replaced and rd_valid stays 1.
- INCSP: SP <= SP+SP_STEP, modulo 2^DATA_WIDTH. On carry-out, set F[0] (sticky).
- DECSP: SP <= SP-SP_STEP. On borrow, set F[1] (sticky).
- F bits clear only by LATCHF, CLEARALL or reset.
- Generic writes to special indices:
  - LATCHC with sel_c==SP_IDX/F_IDX/RV_IDX writes that register, identical to the dedicated latch op.
  - A LATCHF value overrides flag setting only in the cycle of the write; INC/DEC is never concurrent, since there is one command per cycle.
- State machine:
  - IDLE -> CLEAR on accepted CLEARALL.
  - CLEAR: busy=1, cmd_ready=0. Zeroes one register per cycle from index 0 upward using an INDEX_WIDTH counter.
  - After index REGISTERS-1, write SP_RESET into SP and return to IDLE. Total REGISTERS cycles.
  - A pending rd_valid result is unaffected by CLEARALL.
- Reset asserted mid-CLEAR: immediate abort to reset values.
- Undefined indices (>= REGISTERS when not a power of two): reads return 0, writes are ignored.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero. Reads of index 0 return 0 and writes to index 0 are discarded; CLEARALL still takes REGISTERS cycles.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
1. Reset -> LATCHSEL {c=2,b=1,a=2}; LATCHC data=0x1234; READA -> rd_valid 1 cycle after accept, rd_data=0x1234; READB -> 0x0000.
2. LATCHSP 0x0001; DECSP -> SP=0xFFFF, F=0x0002. INCSP -> SP=0x0001, F=0x0003 (both sticky). LATCHF 0 -> READF=0.
3. READRV with rd_ready=0 for 3 cycles -> cmd_ready=0, rd_data stable; LATCHC offered during stall not written until accepted.
4. Fill all 8 registers with nonzero values, CLEARALL -> busy=1 for exactly 8 cycles. Then every READ returns 0 except READSP=SP_RESET.
5. Assert rst_n=0 asynchronously at clear cycle 3 -> busy drops without clock edge; all outputs at reset values.
6. REGFILE_ZERO_REG_EN defined: LATCHSEL c=0,a=0; LATCHC 0xBEEF; READA -> 0x0000. Undefined -> 0xBEEF.

Source files
------------

// File: rtl/regfile_ctrl.sv
// regfile_ctrl : command-driven CPU register file.
//
// Sits between the decode/sequencer stage and the ALU operand/result buses.
// Commands arrive on a valid/ready handshake, one per cycle. Read results leave
// through a registered, back-pressurable port. Three of the registers have fixed
// roles: RV (return value), SP (stack pointer) and F (flags). INCSP and DECSP
// set sticky carry and borrow flags in F. CLEARALL sweeps the file over
// REGISTERS cycles.
//
// Optional feature:
//   `define REGFILE_ZERO_REG_EN : register 0 is hardwired to zero. Reads of
//   index 0 return 0 and writes to index 0 are dropped.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command valid
//   cmd_ready  command accepted when cmd_valid && cmd_ready
//   cmd_op     opcode
//   cmd_sel    {sel_c, sel_b, sel_a}, latched by LATCHSEL
//   cmd_data   write data for the LATCH* ops
//   rd_valid   read result valid
//   rd_ready   consumer accepts the result
//   rd_data    read result
//   busy       high during the CLEARALL sweep
module regfile_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int REGISTERS   = 8,
   parameter int INDEX_WIDTH = $clog2(REGISTERS),
   parameter int RV_IDX      = REGISTERS - 3,
   parameter int SP_IDX      = REGISTERS - 2,
   parameter int F_IDX       = REGISTERS - 1,
   parameter int SP_STEP     = 2,
   parameter int SP_RESET    = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_op,
   input  logic [3*INDEX_WIDTH-1:0] cmd_sel,
   input  logic [DATA_WIDTH-1:0]    cmd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     busy
);

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   typedef enum logic [3:0] {
      OP_NOP      = 4'h0,
      OP_READA    = 4'h1,
      OP_READB    = 4'h2,
      OP_LATCHC   = 4'h3,
      OP_LATCHSEL = 4'h4,
      OP_READSP   = 4'h5,
      OP_READF    = 4'h6,
      OP_READRV   = 4'h7,
      OP_LATCHSP  = 4'h8,
      OP_LATCHF   = 4'h9,
      OP_LATCHRV  = 4'hA,
      OP_INCSP    = 4'hB,
      OP_DECSP    = 4'hC,
      OP_CLEARALL = 4'hE
   } op_e;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_e;

   localparam logic [INDEX_WIDTH-1:0] SP_SEL   = INDEX_WIDTH'(SP_IDX);
   localparam logic [INDEX_WIDTH-1:0] F_SEL    = INDEX_WIDTH'(F_IDX);
   localparam logic [INDEX_WIDTH-1:0] RV_SEL   = INDEX_WIDTH'(RV_IDX);
   localparam logic [INDEX_WIDTH-1:0] LAST_SEL = INDEX_WIDTH'(REGISTERS - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0]  regs_q [REGISTERS];
   logic [DATA_WIDTH-1:0]  regs_d [REGISTERS];
   logic [INDEX_WIDTH-1:0] sel_a_q, sel_a_d;
   logic [INDEX_WIDTH-1:0] sel_b_q, sel_b_d;
   logic [INDEX_WIDTH-1:0] sel_c_q, sel_c_d;
   logic [INDEX_WIDTH-1:0] clr_idx_q, clr_idx_d;
   logic                   rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   state_e                 state_q, state_d;

   // Register-file update requests from the command decoder
   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] wr_idx;
   logic [DATA_WIDTH-1:0]  wr_data;
   logic                   sp_inc, sp_dec, clr_en, clr_last;

   logic                   accept;
   logic [DATA_WIDTH:0]    sp_sum, sp_diff;

   // A stalled result blocks every command, writes included. This keeps
   // commands in order relative to the read that is still waiting.
   assign cmd_ready = (state_q == S_IDLE) && !(rd_valid_q && !rd_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q == S_CLEAR);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

   // The extra top bit catches the carry out of INCSP and the borrow out of DECSP.
   assign sp_sum  = {1'b0, regs_q[SP_IDX]} + (DATA_WIDTH+1)'(SP_STEP);
   assign sp_diff = {1'b0, regs_q[SP_IDX]} - (DATA_WIDTH+1)'(SP_STEP);

   function automatic logic writable(input logic [INDEX_WIDTH-1:0] idx);
      writable = (int'(idx) < REGISTERS) && !(ZERO_REG && (idx == '0));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [INDEX_WIDTH-1:0] idx);
      if ((int'(idx) >= REGISTERS) || (ZERO_REG && (idx == '0))) read_reg = '0;
      else                                                       read_reg = regs_q[idx];
   endfunction

   // ---------------------------------------------------------------------------
   // Command decode, read port and FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned
      // and no latch is inferred.
      state_d    = state_q;
      clr_idx_d  = clr_idx_q;
      sel_a_d    = sel_a_q;
      sel_b_d    = sel_b_q;
      sel_c_d    = sel_c_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      wr_en      = 1'b0;
      wr_idx     = '0;
      wr_data    = cmd_data;
      sp_inc     = 1'b0;
      sp_dec     = 1'b0;
      clr_en     = 1'b0;
      clr_last   = 1'b0;

      // The consumer takes the result. A read accepted in the same cycle
      // overrides this below, so rd_valid stays high.
      if (rd_valid_q && rd_ready) rd_valid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (cmd_op)
                  OP_READA:    begin rd_valid_d = 1'b1; rd_data_d = read_reg(sel_a_q); end
                  OP_READB:    begin rd_valid_d = 1'b1; rd_data_d = read_reg(sel_b_q); end
                  OP_READSP:   begin rd_valid_d = 1'b1; rd_data_d = read_reg(SP_SEL);  end
                  OP_READF:    begin rd_valid_d = 1'b1; rd_data_d = read_reg(F_SEL);   end
                  OP_READRV:   begin rd_valid_d = 1'b1; rd_data_d = read_reg(RV_SEL);  end
                  OP_LATCHC:   begin wr_en = 1'b1; wr_idx = sel_c_q; end
                  OP_LATCHSP:  begin wr_en = 1'b1; wr_idx = SP_SEL;  end
                  OP_LATCHF:   begin wr_en = 1'b1; wr_idx = F_SEL;   end
                  OP_LATCHRV:  begin wr_en = 1'b1; wr_idx = RV_SEL;  end
                  OP_LATCHSEL: begin
                     sel_a_d = cmd_sel[INDEX_WIDTH-1:0];
                     sel_b_d = cmd_sel[2*INDEX_WIDTH-1:INDEX_WIDTH];
                     sel_c_d = cmd_sel[3*INDEX_WIDTH-1:2*INDEX_WIDTH];
                  end
                  OP_INCSP:    sp_inc = 1'b1;
                  OP_DECSP:    sp_dec = 1'b1;
                  OP_CLEARALL: begin
                     state_d   = S_CLEAR;
                     clr_idx_d = '0;
                  end
                  default: ;  // NOP and the reserved opcodes
               endcase
            end
         end
         S_CLEAR: begin
            clr_en    = 1'b1;
            clr_last  = (clr_idx_q == LAST_SEL);
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Register-file next state
   // ---------------------------------------------------------------------------
   always_comb begin
      regs_d = regs_q;
      if (wr_en && writable(wr_idx)) regs_d[wr_idx] = wr_data;
      if (sp_inc) begin
         regs_d[SP_IDX] = sp_sum[DATA_WIDTH-1:0];
         if (sp_sum[DATA_WIDTH]) regs_d[F_IDX][0] = 1'b1;
      end
      if (sp_dec) begin
         regs_d[SP_IDX] = sp_diff[DATA_WIDTH-1:0];
         if (sp_diff[DATA_WIDTH]) regs_d[F_IDX][1] = 1'b1;
      end
      if (clr_en) begin
         regs_d[clr_idx_q] = '0;
         // The sweep has already zeroed SP. The last step restores its reset value.
         if (clr_last) regs_d[SP_IDX] = DATA_WIDTH'(SP_RESET);
      end
   end

   // ---------------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array is reset explicitly because the reset contents
         // of the file (all zero, SP = SP_RESET) are architecturally visible.
         for (int i = 0; i < REGISTERS; i++) begin
            regs_q[i] <= (i == SP_IDX) ? DATA_WIDTH'(SP_RESET) : '0;
         end
         sel_a_q    <= '0;
         sel_b_q    <= '0;
         sel_c_q    <= '0;
         clr_idx_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         state_q    <= S_IDLE;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples pre-edge values.
         regs_q     <= regs_d;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         sel_c_q    <= sel_c_d;
         clr_idx_q  <= clr_idx_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         state_q    <= state_d;
      end
   end

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl : directed, scoreboard-checked bench for regfile_ctrl.
// Read stimulus pushes its hand-computed result into a queue. A monitor pops the
// queue and compares whenever the DUT hands over a result.
`timescale 1ns/1ps
module tb_regfile_ctrl;

   localparam int DW       = 16;
   localparam int IW       = 3;
   localparam int SP_RESET = 0;
`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   localparam logic [3:0] NOP = 4'h0, READA = 4'h1, READB = 4'h2, LATCHC = 4'h3,
                          LATCHSEL = 4'h4, READSP = 4'h5, READF = 4'h6, READRV = 4'h7,
                          LATCHSP = 4'h8, LATCHF = 4'h9, LATCHRV = 4'hA, INCSP = 4'hB,
                          DECSP = 4'hC, RSVD_D = 4'hD, CLEARALL = 4'hE;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [3:0]      cmd_op;
   logic [3*IW-1:0] cmd_sel;
   logic [DW-1:0]   cmd_data;
   logic            rd_valid;
   logic            rd_ready;
   logic [DW-1:0]   rd_data;
   logic            busy;

   typedef struct {
      string         name;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   regfile_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_sel   (cmd_sel),
      .cmd_data  (cmd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [3*IW-1:0] sel3(input int c, input int b, input int a);
      logic [IW-1:0] cc, bb, aa;
      cc = IW'(c);
      bb = IW'(b);
      aa = IW'(a);
      return {cc, bb, aa};
   endfunction

   // Offer one command and hold it until it is accepted. The task returns 1 ns
   // after the accepting edge, so two calls in a row give back-to-back commands.
   task automatic issue(input logic [3:0] op, input logic [3*IW-1:0] sel, input logic [DW-1:0] data);
      int n;
      n         = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_sel   = sel;
      cmd_data  = data;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout op=%0h: got cmd_ready=0 for 50 cycles, required 1", op);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic rd(input logic [3:0] op, input string name, input logic [DW-1:0] exp);
      exp_t e;
      e.name = name;
      e.data = exp;
      sb_q.push_back(e);
      issue(op, '0, '0);
   endtask

   // Monitor: one transfer per falling edge where valid && ready is seen.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && rd_valid && rd_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got rd_data=%h, required no result", rd_data);
            end else begin
               e = sb_q.pop_front();
               check(e.name, 32'(rd_data), 32'(e.data));
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
      cmd_sel   = '0;
      cmd_data  = '0;
      rd_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_rd_valid",  32'(rd_valid), 0);
      check("rst_rd_data",   32'(rd_data), 0);
      check("rst_busy",      32'(busy), 0);

      // 1: select, write, read back; READB is back-to-back and replaces rd_data
      issue(LATCHSEL, sel3(2, 1, 2), '0);
      issue(LATCHC, '0, 16'h1234);
      rd(READA, "t1_reada", 16'h1234);
      check("t1_rd_valid_latency", 32'(rd_valid), 1);
      rd(READB, "t1_readb", 16'h0000);
      issue(LATCHRV, '0, 16'h5A5A);

      // A generic write to the SP index behaves like LATCHSP
      issue(LATCHSEL, sel3(6, 1, 2), '0);
      issue(LATCHC, '0, 16'h0042);
      rd(READSP, "generic_sp_write", 16'h0042);

      // 2: SP wrap in both directions with sticky flags
      issue(LATCHSP, '0, 16'h0001);
      issue(DECSP, '0, '0);
      rd(READSP, "t2_dec_sp", 16'hFFFF);
      rd(READF,  "t2_dec_f",  16'h0002);
      issue(INCSP, '0, '0);
      rd(READSP, "t2_inc_sp", 16'h0001);
      rd(READF,  "t2_inc_f",  16'h0003);
      issue(LATCHF, '0, 16'h0000);
      rd(READF,  "t2_latchf_clear", 16'h0000);
      issue(RSVD_D, '0, 16'hFFFF);
      rd(READSP, "reserved_op_nop", 16'h0001);

      // 3: output stall blocks a write until the result is taken
      issue(LATCHSEL, sel3(3, 3, 2), '0);
      rd(READB, "t3_pre_write", 16'h0000);
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      rd(READRV, "t3_readrv", 16'h5A5A);
      cmd_valid = 1'b1;
      cmd_op    = LATCHC;
      cmd_sel   = '0;
      cmd_data  = 16'h7777;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("t3_stall_ready_c%0d", i), 32'(cmd_ready), 0);
         check($sformatf("t3_stall_valid_c%0d", i), 32'(rd_valid), 1);
         check($sformatf("t3_stall_data_c%0d", i),  32'(rd_data), 32'h5A5A);
         @(posedge clk);
         #1;
      end
      rd_ready = 1'b1;
      @(negedge clk);
      check("t3_release_ready", 32'(cmd_ready), 1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      rd(READB, "t3_write_after_stall", 16'h7777);

      // 4: fill every register, then CLEARALL
      for (int i = 0; i < 8; i++) begin
         issue(LATCHSEL, sel3(i, 0, 0), '0);
         issue(LATCHC, '0, 16'h1100 + 16'(i));
      end
      rd(READF, "t4_fill_f", 16'h1107);
      issue(CLEARALL, '0, '0);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      check("t4_busy_cycles", 32'(n), 8);
      check("t4_ready_after_clear", 32'(cmd_ready), 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         issue(LATCHSEL, sel3(0, 0, i), '0);
         rd(READA, $sformatf("t4_cleared_r%0d", i), (i == 6) ? 16'(SP_RESET) : 16'h0000);
      end
      rd(READSP, "t4_cleared_sp", 16'(SP_RESET));

      // 5: asynchronous reset in the middle of the sweep
      issue(LATCHRV, '0, 16'h3333);
      rd(READRV, "t5_pre_rv", 16'h3333);
      issue(CLEARALL, '0, '0);
      check("t5_busy_in_clear", 32'(busy), 1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_busy",     32'(busy), 0);
      check("t5_async_rd_valid", 32'(rd_valid), 0);
      check("t5_async_rd_data",  32'(rd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t5_ready_after_reset", 32'(cmd_ready), 1);
      rd(READA,  "t5_reset_r0", 16'h0000);
      rd(READRV, "t5_reset_rv", 16'h0000);
      rd(READSP, "t5_reset_sp", 16'(SP_RESET));
      rd(READF,  "t5_reset_f",  16'h0000);

      // 6: register 0 behaviour
      issue(LATCHSEL, sel3(0, 0, 0), '0);
      issue(LATCHC, '0, 16'hBEEF);
      rd(READA, "t6_reg0", ZERO_REG ? 16'h0000 : 16'hBEEF);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
